uart_rx_param: RTL and testbench
================================

Name: uart_rx_param

Overview:
- Parametrised serial receiver, successor to the fixed 8N1 receiver.
- Sits between the `serial_in` pin and the byte consumer.
- Adds configurable data width, parity, stop-bit count and baud divisor.
- Adds input synchronisation, false-start rejection, and parity/framing error reporting with line-idle recovery.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per bit period (50 MHz / 115200). Legal range ≥ 4.
- DATA_BITS, 8, data bits per frame, LSB first. Legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame: 1 or 2.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous reset, active-low.
- serial_in  in  1  asynchronous serial line; idles high.
- o_Byte  out  DATA_BITS  last received data word; held until the next o_done.
- o_done  out  1  one-cycle pulse; a frame finished (good or bad).
- o_parity_err  out  1  valid with o_done; parity mismatch (always 0 when PARITY = 0).
- o_frame_err  out  1  valid with o_done; a stop bit sampled low.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: while reset_n = 0 at a clock edge:
  - state = IDLE.
  - o_Byte = 0, o_done = 0, o_parity_err = 0, o_frame_err = 0, o_busy = 0.
  - Synchroniser flops = 1; bit counter and tick counter = 0.
  - Reset mid-frame aborts the frame with no o_done.
- Synchroniser: two flops on serial_in; `rx_s` is the second flop. All decisions use `rx_s` (2-cycle input latency).
- Tick counter: counts 0..CLKS_PER_BIT-1. Mid-bit = CLKS_PER_BIT/2 (integer division).
- State machine:
  - IDLE: on `rx_s` = 0 go to START, tick counter = 0.
  - START: when tick reaches CLKS_PER_BIT/2 - 1, sample `rx_s`.
    - 0: go to DATA, tick = 0, bit index = 0.
    - 1: false start (glitch); return to IDLE, no o_done.
  - DATA: when tick reaches CLKS_PER_BIT-1 (mid-bit), shift `rx_s` into bit[index], tick = 0.
    - After bit DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY: sample at mid-bit.
    - Parity error if (XOR of data ^ sampled bit) != (PARITY == 1 ? 1 : 0).
    - So odd mode requires an odd count of ones including the parity bit; even mode requires an even count.
  - STOP: sample at mid-bit.
    - Any stop sample = 0 sets the frame error.
    - With STOP_BITS = 2, both stops are sampled, one bit period apart.
    - After the last stop sample, on the same edge: o_Byte <= shift register, error flags updated, o_done = 1 for exactly one cycle.
    - Next state: IDLE if `rx_s` = 1, else WAIT_IDLE.
  - WAIT_IDLE: stay until `rx_s` = 1, then go to IDLE. Prevents a held-low break from being read as repeated 0x00 frames.
- o_done timing: asserted at mid-point of the final stop bit, i.e. ((1 + DATA_BITS + P + STOP_BITS - 0.5) × CLKS_PER_BIT + 2 ± 1) cycles after the serial_in falling edge, where P = 1 if PARITY != 0, else 0.
- Error flags: registered with o_done and held until the next o_done. The data word is delivered even when an error flag is set.
- Back-to-back frames: a start edge arriving half a bit after the last stop sample is accepted (IDLE is reached before it).
- Timing tolerance: no fractional baud; tolerance is ±½ bit accumulated over the frame.

Test Plan:
- CLKS_PER_BIT = 16, 8N1. Bench TX sends 0x0F, then 0xAB back-to-back.
  - Required: two o_done pulses.
  - o_Byte = 0x0F, then 0xAB; both error flags 0 each time.
- PARITY = 2 (even), byte 0xAB (five ones).
  - Correct parity bit 1 → o_parity_err = 0.
  - Forced parity bit 0 → o_done with o_parity_err = 1, o_Byte = 0xAB.
- Glitch: serial_in low for 5 cycles (< 8) then high.
  - Required: no o_done; o_busy returns to 0 within 10 cycles.
- Stop bit driven low for frame 0x55, line then held low 100 cycles.
  - Required: exactly one o_done with o_frame_err = 1.
  - State stays in WAIT_IDLE, no further frames until the line returns high.
  - A following 0x3C frame is received cleanly.
- DATA_BITS = 7, STOP_BITS = 2, PARITY = 1 (odd), word 0x41.
  - Required: o_Byte = 7'h41, no errors.
  - o_done lands within ±1 cycle of the predicted mid-second-stop time.
- reset_n pulled low during data bit 3 of 0xC3.
  - Required: all outputs 0 next cycle, no o_done.
  - The next full frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable data width, parity and stop bits,
// with a two-flop input synchroniser, false-start rejection and error flags.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] o_Byte,
  output logic                 o_done,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_busy
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST  = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST  = BW'(STOP_BITS - 1);
  localparam logic          ODD_PARITY = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic [DATA_BITS-1:0]   byte_d;
  logic                   done_d, perr_out_d, ferr_out_d;
  logic                   stop_bad;

  assign rx_s   = sync_q[1];
  assign o_busy = (state_q != S_IDLE);

  // NOTE: every always_comb output gets a default before the case, so no
  // path can leave a variable unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q + TW'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    byte_d     = o_Byte;
    done_d     = 1'b0;
    perr_out_d = o_parity_err;
    ferr_out_d = o_frame_err;
    stop_bad   = ferr_q | ~rx_s;

    case (state_q)
      S_IDLE: begin
        tick_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (tick_q == TICK_HALF) begin
          tick_d = '0;
          bit_d  = '0;
          perr_d = 1'b0;
          ferr_d = 1'b0;
          // A line that is high again at mid-start was only a glitch.
          state_d = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick_q == TICK_LAST) begin
          tick_d  = '0;
          perr_d  = ((^shift_q) ^ rx_s) != ODD_PARITY;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (bit_q == STOP_LAST) begin
            bit_d      = '0;
            byte_d     = shift_q;
            done_d     = 1'b1;
            perr_out_d = perr_q;
            ferr_out_d = stop_bad;
            // A line still low here is a break; wait for idle before re-arming.
            state_d    = rx_s ? S_IDLE : S_WAIT_IDLE;
          end else begin
            bit_d  = bit_q + BW'(1);
            ferr_d = stop_bad;
          end
        end
      end
      S_WAIT_IDLE: begin
        tick_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: begin
        tick_d  = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sync_q       <= 2'b11;
      tick_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      o_Byte       <= '0;
      o_done       <= 1'b0;
      o_parity_err <= 1'b0;
      o_frame_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= {sync_q[0], serial_in};
      tick_q       <= tick_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      ferr_q       <= ferr_d;
      o_Byte       <= byte_d;
      o_done       <= done_d;
      o_parity_err <= perr_out_d;
      o_frame_err  <= ferr_out_d;
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: three receivers (8N1, 8E1, 7O2) fed by
// a bench transmitter; a behavioural model predicts word, flags and timing.
module tb_uart_rx_param;

  localparam int C = 16;

  typedef struct {
    logic [8:0] data;
    logic       perr;
    logic       ferr;
    int         due;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [2:0] ser;
  int         cyc;
  int         checks;
  int         errors;

  logic [7:0] byte0, byte1;
  logic [6:0] byte2;
  logic       done0, done1, done2;
  logic       perr0, perr1, perr2;
  logic       ferr0, ferr1, ferr2;
  logic       busy0, busy1, busy2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_rx0 (
    .clock(clk), .reset_n(reset_n), .serial_in(ser[0]), .o_Byte(byte0), .o_done(done0),
    .o_parity_err(perr0), .o_frame_err(ferr0), .o_busy(busy0));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_rx1 (
    .clock(clk), .reset_n(reset_n), .serial_in(ser[1]), .o_Byte(byte1), .o_done(done1),
    .o_parity_err(perr1), .o_frame_err(ferr1), .o_busy(busy1));

  uart_rx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_rx2 (
    .clock(clk), .reset_n(reset_n), .serial_in(ser[2]), .o_Byte(byte2), .o_done(done2),
    .o_parity_err(perr2), .o_frame_err(ferr2), .o_busy(busy2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lane_db(input int lane);
    return (lane == 2) ? 7 : 8;
  endfunction

  function automatic int lane_par(input int lane);
    return (lane == 0) ? 0 : ((lane == 1) ? 2 : 1);
  endfunction

  function automatic int lane_sb(input int lane);
    return (lane == 2) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // All callers sit just after a rising edge; hold keeps that alignment.
  task automatic hold(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int lane, input logic [8:0] data, input bit flip_par,
                            input logic [1:0] stop_vals, input bit release_line, input int gap);
    exp_t e;
    int   db, pm, sb, ones;
    logic par_bit;
    db = lane_db(lane);
    pm = lane_par(lane);
    sb = lane_sb(lane);
    e.data  = data & 9'((1 << db) - 1);
    ones    = $countones(e.data);
    par_bit = ((pm == 1) ? (ones % 2 == 0) : (ones % 2 == 1)) ^ flip_par;
    e.perr  = (pm == 0) ? 1'b0
            : (pm == 1) ? ((ones + par_bit) % 2 == 0)
            :             ((ones + par_bit) % 2 == 1);
    e.ferr  = (stop_vals[0] == 1'b0) || (sb == 2 && stop_vals[1] == 1'b0);
    e.due   = cyc + 2 + C / 2 + (db + (pm != 0 ? 1 : 0) + sb) * C;
    case (lane)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
    ser[lane] = 1'b0;
    hold(C);
    for (int i = 0; i < db; i++) begin
      ser[lane] = e.data[i];
      hold(C);
    end
    if (pm != 0) begin
      ser[lane] = par_bit;
      hold(C);
    end
    for (int i = 0; i < sb; i++) begin
      ser[lane] = stop_vals[i];
      hold(C);
    end
    if (release_line) begin
      ser[lane] = 1'b1;
      hold(gap);
    end
  endtask

  task automatic rand_frame(input int lane);
    logic [8:0] d;
    bit         flip;
    logic [1:0] stops;
    d     = 9'($urandom);
    flip  = (lane_par(lane) != 0) && ($urandom_range(0, 3) == 0);
    stops = {($urandom_range(0, 5) != 0), ($urandom_range(0, 5) != 0)};
    send_frame(lane, d, flip, stops, 1'b1, $urandom_range(1, C));
  endtask

  task automatic check_done(input int lane, input logic [8:0] act, input logic pe, input logic fe);
    exp_t e;
    int   n;
    n = (lane == 0) ? q0.size() : ((lane == 1) ? q1.size() : q2.size());
    check($sformatf("lane%0d_done_expected", lane), (n != 0), 1);
    if (n == 0) return;
    case (lane)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    check($sformatf("lane%0d_byte", lane), act, e.data);
    check($sformatf("lane%0d_parity_err", lane), pe, e.perr);
    check($sformatf("lane%0d_frame_err", lane), fe, e.ferr);
    checks++;
    if (cyc < e.due - 1 || cyc > e.due + 1) begin
      errors++;
      $display("FAIL lane%0d_done_time: cycle %0d required %0d +/-1", lane, cyc, e.due);
    end
  endtask

  always @(negedge clk) begin
    if (done0) check_done(0, {1'b0, byte0}, perr0, ferr0);
    if (done1) check_done(1, {1'b0, byte1}, perr1, ferr1);
    if (done2) check_done(2, {2'b00, byte2}, perr2, ferr2);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    ser     = 3'b111;
    hold(3);
    check("reset_byte", byte0, 0);
    check("reset_done", done0, 0);
    check("reset_parity_err", perr0, 0);
    check("reset_frame_err", ferr0, 0);
    check("reset_busy", {busy2, busy1, busy0}, 0);
    reset_n = 1'b1;
    hold(5);

    // Back-to-back 8N1, even-parity good/bad, and 7O2 with timing.
    fork
      begin
        send_frame(0, 9'h0F, 1'b0, 2'b11, 1'b1, 0);
        send_frame(0, 9'hAB, 1'b0, 2'b11, 1'b1, C);
      end
      begin
        send_frame(1, 9'hAB, 1'b0, 2'b11, 1'b1, C);
        send_frame(1, 9'hAB, 1'b1, 2'b11, 1'b1, C);
      end
      send_frame(2, 9'h41, 1'b0, 2'b11, 1'b1, C);
    join
    hold(C);

    // Short low glitch must not start a frame.
    ser[0] = 1'b0;
    hold(5);
    ser[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!busy0) break;
      hold(1);
    end
    check("glitch_busy_clears", busy0, 0);
    hold(C);

    // Low stop bit followed by a held-low break.
    send_frame(0, 9'h55, 1'b0, 2'b00, 1'b0, 0);
    hold(100);
    check("break_wait_idle_busy", busy0, 1);
    ser[0] = 1'b1;
    hold(4);
    check("break_release_idle", busy0, 0);
    send_frame(0, 9'h3C, 1'b0, 2'b11, 1'b1, C);

    // Reset during data bit 3 of 0xC3.
    ser[0] = 1'b0;
    hold(C);
    ser[0] = 1'b1; hold(C);
    ser[0] = 1'b1; hold(C);
    ser[0] = 1'b0; hold(C);
    ser[0] = 1'b0; hold(C / 2);
    reset_n = 1'b0;
    ser[0]  = 1'b1;
    hold(1);
    check("midframe_reset_byte", byte0, 0);
    check("midframe_reset_flags", {done0, perr0, ferr0}, 0);
    check("midframe_reset_busy", busy0, 0);
    reset_n = 1'b1;
    hold(4);
    send_frame(0, 9'h5A, 1'b0, 2'b11, 1'b1, C);

    fork
      for (int k = 0; k < 10; k++) rand_frame(0);
      for (int k = 0; k < 10; k++) rand_frame(1);
      for (int k = 0; k < 10; k++) rand_frame(2);
    join

    hold(4 * C);
    check("lane0_drained", q0.size(), 0);
    check("lane1_drained", q1.size(), 0);
    check("lane2_drained", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
